frame_sequencer: RTL

Sequences one compressive-sensing frame through a shared 64x8 frame buffer. The block owns the buffer and grants it to three requesters in strict order: the SPI receiver fills it, the compression engine gets exclusive read/write access, and the SPI sender drains it. It sits between `signalReceive`, the compression datapath and `sending` in the top level, replacing ad-hoc counter logic with one state machine.

---
 rtl/cs_pkg.sv | 14 +
 rtl/frame_ram.sv | 26 ++
 rtl/frame_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cs_pkg.sv
// Shared definitions for the compressive-sensing frame path.
// Holds the default frame geometry and the sequencer state encoding.
package cs_pkg;
  localparam int DEPTH  = 64;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    PROC  = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;
endpackage

// File: rtl/frame_ram.sv
// Single-port synchronous frame buffer, DEPTH x DATA_W.
// Write-first: a write also returns the written word on rdata next cycle.
// Ports: clk, we, addr, wdata in; rdata out (registered, 1-cycle latency).
// Contents are never cleared.
module frame_ram #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: owns the shared frame buffer and hands it, in order, to the
// SPI receiver (FILL), the compression engine (PROC) and the SPI sender (DRAIN).
// Ports:
//   clk, rst (sync, active-high)
//   SSEL (active-low select), rx_valid/rx_data      : receive side
//   proc_start, proc_addr/we/wdata, proc_rdata, proc_done : engine side
//   tx_data, tx_ready, tx_byte_sent                  : send side
//   busy, frame_done, overrun, abort                 : status
import cs_pkg::*;

module frame_sequencer #(
  parameter int DEPTH  = cs_pkg::DEPTH,
  parameter int DATA_W = cs_pkg::DATA_W,
  parameter int ADDR_W = cs_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SSEL,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              proc_start,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic              proc_we,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic [DATA_W-1:0] proc_rdata,
  input  logic              proc_done,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  input  logic              tx_byte_sent,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun,
  output logic              abort
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  seq_state_t        state, state_n;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic              tx_ready_n, proc_start_n, frame_done_n, overrun_n, abort_n;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  frame_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tx_ready   <= 1'b0;
      proc_start <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      abort      <= 1'b0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      tx_ready   <= tx_ready_n;
      proc_start <= proc_start_n;
      frame_done <= frame_done_n;
      overrun    <= overrun_n;
      abort      <= abort_n;
    end
  end

  // Next state, status pulses and buffer port mux. The port owner is the
  // current state, so engine signals never reach the RAM outside PROC.
  always_comb begin
    state_n      = state;
    wr_ptr_n     = wr_ptr;
    rd_ptr_n     = rd_ptr;
    tx_ready_n   = 1'b0;
    proc_start_n = 1'b0;
    frame_done_n = 1'b0;
    overrun_n    = 1'b0;
    abort_n      = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;

    case (state)
      IDLE: begin
        if (!SSEL) begin
          state_n  = FILL;
          wr_ptr_n = '0;
        end
      end
      FILL: begin
        ram_addr  = wr_ptr;
        ram_we    = rx_valid;
        ram_wdata = rx_data;
        if (rx_valid) wr_ptr_n = wr_ptr + 1'b1;
        // A final byte wins over a simultaneous SSEL release.
        if (rx_valid && wr_ptr == LAST) begin
          state_n      = PROC;
          proc_start_n = 1'b1;
        end else if (SSEL) begin
          state_n = IDLE;
          abort_n = 1'b1;
        end
      end
      PROC: begin
        ram_addr  = proc_addr;
        ram_we    = proc_we;
        ram_wdata = proc_wdata;
        overrun_n = rx_valid;
        if (proc_done) begin
          state_n  = DRAIN;
          rd_ptr_n = '0;
        end
      end
      DRAIN: begin
        // RAM address follows rd_ptr; tx_ready rises one cycle after any
        // pointer change, once the registered read has caught up.
        ram_addr = rd_ptr;
        if (tx_ready && tx_byte_sent) begin
          rd_ptr_n = rd_ptr + 1'b1;
          if (rd_ptr == LAST) begin
            frame_done_n = 1'b1;
            state_n      = IDLE;
          end
        end else begin
          tx_ready_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign proc_rdata = (state == PROC)  ? ram_rdata : '0;
  assign tx_data    = (state == DRAIN) ? ram_rdata : '0;
endmodule
